axi4lite_master: RTL and testbench
==================================

# axi4lite_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response stream into AXI4-Lite write (AW/W/B) and read (AR/R) transactions. It sits between on-chip control logic (register sequencers, test drivers) and the team's AXI4-Lite memory and peripheral targets. It uses the same 16-bit address and 32-bit data geometry as those targets. It issues exactly one transaction at a time and reports the slave's response code back upstream.

## Interface
- ADDR_W, 16, AXI address width (byte address)
- DATA_W, 32, AXI data width; strobe width is DATA_W/8
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both are high at a clock edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- cmd_wstrb  in  DATA_W/8  byte strobes; ignored for reads
- cmd_prot  in  3  driven onto awprot/arprot
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both are high at a clock edge
- rsp_write  out  1  echoes cmd_write of the completed transaction
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  bresp or rresp returned by the slave
- awvalid/awready/awaddr/awprot  out/in/out/out  1/1/ADDR_W/3  write address channel
- wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_W/DATA_W/8  write data channel
- bvalid/bready/bresp  in/out/in  1/1/2  write response channel
- arvalid/arready/araddr/arprot  out/in/out/out  1/1/ADDR_W/3  read address channel
- rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_W/2  read data channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: cmd_ready=1.
  - On a command handshake, capture addr/wdata/wstrb/prot/write into output registers.
  - Go to WR_REQ (set awvalid=1, wvalid=1) or RD_REQ (set arvalid=1).
- WR_REQ: AW and W complete independently.
  - awvalid clears on the edge where awvalid&&awready.
  - wvalid clears on the edge where wvalid&&wready.
  - Same-cycle and either-order completion are both legal.
  - Once both are done, go to WR_RESP. The AW/W done flags are internal and clear in IDLE.
- WR_RESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_rdata=0, go to DONE.
- RD_REQ: arvalid held until arvalid&&arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata and rresp, go to DONE.
- DONE: rsp_valid=1. On rsp_ready, go to IDLE.
- AXI rule: no valid deasserts before its handshake. Address, data, strobe and prot stay stable while their valid is high.
- Error codes SLVERR/DECERR pass through unchanged. The block never retries.
- Reset mid-operation:
  - The FSM returns to IDLE and all valids/readies go to 0 at that edge; the transaction is abandoned.
  - The system resets the slave together with the master.

## Timing
- Reset values:
  - cmd_ready: 0 while rst=1.
  - Valids: awvalid=wvalid=arvalid=0, rsp_valid=0.
  - Readies: bready=rready=0.
  - awaddr/araddr=0, wdata=0, wstrb=0, awprot/arprot=0, rsp_rdata=0, rsp_resp=0, rsp_write=0.
- All AXI and rsp_* outputs are registered. cmd_ready, bready and rready decode directly from the state register.
- Valids rise the cycle after command acceptance.
- bready/rready rise the cycle after the final request-channel handshake.
- rsp_valid rises the cycle after the B/R handshake.
- Zero-wait slave (ready tied high, response in the next cycle): command accepted at T0, rsp_valid at T3, next command accepted at T4 if rsp_ready=1 at T3. Throughput is one transaction per 4 cycles.
- Slave stalls add cycles 1:1 with no upper bound (no timeout).
- Against a target that raises awready and wready together one cycle after seeing both valids, with bvalid in the same cycle: rsp_valid appears 4 cycles after command acceptance.

## Structure
- Shared package axi4lite_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - the FSM state enum
  - the default ADDR_W/DATA_W
- Single module with no sub-module. Channel logic is small enough that splitting it adds only port plumbing.

## Test plan
- Write to addr 0x0010, data 0xDEADBEEF, wstrb 0xF, zero-wait slave → awaddr 0x0010, wdata 0xDEADBEEF on one cycle; rsp_valid at T3 with rsp_write=1, rsp_resp=00.
- Read from 0x0010 after that write, slave returns 0xDEADBEEF → rsp_rdata=0xDEADBEEF, rsp_write=0, rsp_resp=00.
- awready asserted 3 cycles before wready → awvalid drops after its handshake; wvalid and wdata stay stable until wready; only then bready=1.
- Slave returns bresp=10 and later rresp=11 → rsp_resp=10 and 11 respectively; the FSM returns to IDLE normally.
- rsp_ready held low 5 cycles → rsp_valid and rsp_rdata stay stable; cmd_ready stays 0; a new cmd_valid is not accepted until the response is consumed.
- rst asserted while in WR_REQ with awvalid=1 → next cycle all valids/readies are 0, state is IDLE, and a fresh read then completes correctly.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_pkg
//   Shared definitions for the AXI4-Lite initiator and its neighbours:
//   default bus geometry, the AXI response codes and the master FSM states.
//   No ports; imported with "import axi4lite_pkg::*;".
// -----------------------------------------------------------------------------
package axi4lite_pkg;

    // Default bus geometry shared with the memory and peripheral targets.
    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 32;

    // AXI response codes (BRESP / RRESP).
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Master FSM states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } axi_state_e;

endpackage

// File: rtl/axi4lite_master.sv
// -----------------------------------------------------------------------------
// axi4lite_master
//   Single-outstanding AXI4-Lite initiator. Accepts one command at a time on
//   the cmd_* stream, runs the matching AXI4-Lite write (AW/W/B) or read
//   (AR/R) transaction, and returns the slave's response on the rsp_* stream.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata/
//   cmd_wstrb/cmd_prot       command payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_write/rdata/resp     response payload (rdata is 0 for writes)
//   aw*, w*, b*, ar*, r*     AXI4-Lite master channels
//   dbg_state                current FSM state, for observation only
//
// Handshake semantics (all streams, AXI and cmd/rsp alike): a transfer occurs
// on a rising clk edge where valid and ready are both high. A source never
// drops valid, and never changes the payload, until that transfer occurs;
// ready may be raised or lowered freely.
// -----------------------------------------------------------------------------
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,

    // Command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    input  logic [2:0]            cmd_prot,

    // Response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    // Write address channel
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awprot,

    // Write data channel
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,

    // Write response channel
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,

    // Read address channel
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arprot,

    // Read data channel
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,

    // Debug
    output axi_state_e            dbg_state
);

    axi_state_e state_q;
    axi_state_e state_d;

    // AW and W complete independently; these remember which has finished.
    logic aw_done_q;
    logic w_done_q;

    logic cmd_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic rsp_hs;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign rsp_hs = rsp_valid && rsp_ready;

    assign dbg_state = state_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    state_d = cmd_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                // Leave once each channel has completed, counting a handshake
                // happening on this very edge.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    state_d = S_DONE;
                end
            end
            S_RD_REQ: begin
                if (ar_hs) begin
                    state_d = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (r_hs) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state-decoded outputs
    // cmd_ready is additionally masked by rst so nothing is accepted during
    // reset even though the state register already reads IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        bready    = 1'b0;
        rready    = 1'b0;
        case (state_q)
            S_IDLE:    cmd_ready = !rst;
            S_WR_RESP: bready    = 1'b1;
            S_RD_RESP: rready    = 1'b1;
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Write-channel completion flags, cleared whenever the FSM is idle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || (state_q == S_IDLE)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered AXI request channels. Valids rise the cycle after command
    // acceptance and fall on their own handshake edge. Payload registers load
    // only on command acceptance, which can happen only in IDLE where every
    // valid is low, so payload is stable for the whole life of a valid.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            arvalid <= 1'b0;
            awaddr  <= '0;
            awprot  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            araddr  <= '0;
            arprot  <= '0;
        end else begin
            if (cmd_hs) begin
                if (cmd_write) begin
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    awaddr  <= cmd_addr;
                    awprot  <= cmd_prot;
                    wdata   <= cmd_wdata;
                    wstrb   <= cmd_wstrb;
                end else begin
                    arvalid <= 1'b1;
                    araddr  <= cmd_addr;
                    arprot  <= cmd_prot;
                end
            end else begin
                if (aw_hs) begin
                    awvalid <= 1'b0;
                end
                if (w_hs) begin
                    wvalid <= 1'b0;
                end
                if (ar_hs) begin
                    arvalid <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered response stream. Loaded on the B or R handshake; response
    // codes pass through untouched, including SLVERR and DECERR.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            if (b_hs) begin
                rsp_valid <= 1'b1;
                rsp_write <= 1'b1;
                rsp_rdata <= '0;
                rsp_resp  <= bresp;
            end else if (r_hs) begin
                rsp_valid <= 1'b1;
                rsp_write <= 1'b0;
                rsp_rdata <= rdata;
                rsp_resp  <= rresp;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_master
//   Directed bench for axi4lite_master. The slave side is driven by hand,
//   cycle by cycle, from a single initial block. Inputs change and outputs are
//   sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_axi4lite_master;
    import axi4lite_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic                cmd_write = 1'b0;
    logic [ADDR_W-1:0]   cmd_addr  = '0;
    logic [DATA_W-1:0]   cmd_wdata = '0;
    logic [DATA_W/8-1:0] cmd_wstrb = '0;
    logic [2:0]          cmd_prot  = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic                rsp_write;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [1:0]          rsp_resp;
    logic                awvalid;
    logic                awready = 1'b0;
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                wvalid;
    logic                wready = 1'b0;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid = 1'b0;
    logic                bready;
    logic [1:0]          bresp = 2'b00;
    logic                arvalid;
    logic                arready = 1'b0;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                rvalid = 1'b0;
    logic                rready;
    logic [DATA_W-1:0]   rdata = '0;
    logic [1:0]          rresp = 2'b00;
    axi_state_e          dbg_state;

    axi4lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .cmd_prot  (cmd_prot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awprot    (awprot),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arprot    (arprot),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .dbg_state (dbg_state)
    );

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every valid and ready the master drives, plus the state.
    task automatic check_ctrl(input string tag, input logic aw, input logic w,
                              input logic ar, input logic b, input logic r,
                              input logic rv, input logic cr, input axi_state_e st);
        check({tag, ".awvalid"},   32'(awvalid),   32'(aw));
        check({tag, ".wvalid"},    32'(wvalid),    32'(w));
        check({tag, ".arvalid"},   32'(arvalid),   32'(ar));
        check({tag, ".bready"},    32'(bready),    32'(b));
        check({tag, ".rready"},    32'(rready),    32'(r));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(cr));
        check({tag, ".state"},     32'(dbg_state), 32'(st));
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // ---- reset values
        rst = 1'b1;
        tick();
        tick();
        check_ctrl("rst", 0, 0, 0, 0, 0, 0, 0, S_IDLE);
        check("rst.awaddr",    32'(awaddr),    32'h0);
        check("rst.araddr",    32'(araddr),    32'h0);
        check("rst.wdata",     wdata,          32'h0);
        check("rst.wstrb",     32'(wstrb),     32'h0);
        check("rst.awprot",    32'(awprot),    32'h0);
        check("rst.arprot",    32'(arprot),    32'h0);
        check("rst.rsp_rdata", rsp_rdata,      32'h0);
        check("rst.rsp_resp",  32'(rsp_resp),  32'h0);
        check("rst.rsp_write", 32'(rsp_write), 32'h0);
        rst = 1'b0;
        #1;
        check("idle.cmd_ready", 32'(cmd_ready), 32'h1);

        // ---- 1: write 0x0010 <= 0xDEADBEEF, zero-wait slave
        awready = 1'b1; wready = 1'b1; arready = 1'b1; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0010;
        cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF; cmd_prot = 3'b010;
        tick();                                   // T0 edge: accepted
        cmd_valid = 1'b0;
        check_ctrl("wr1.t1", 1, 1, 0, 0, 0, 0, 0, S_WR_REQ);
        check("wr1.awaddr", 32'(awaddr), 32'h0010);
        check("wr1.wdata",  wdata,       32'hDEADBEEF);
        check("wr1.wstrb",  32'(wstrb),  32'hF);
        check("wr1.awprot", 32'(awprot), 32'h2);
        tick();                                   // T1 edge: AW and W together
        check_ctrl("wr1.t2", 0, 0, 0, 1, 0, 0, 0, S_WR_RESP);
        bvalid = 1'b1; bresp = RESP_OKAY;
        tick();                                   // T2 edge: B handshake
        bvalid = 1'b0;
        check_ctrl("wr1.t3", 0, 0, 0, 0, 0, 1, 0, S_DONE);
        check("wr1.rsp_write", 32'(rsp_write), 32'h1);
        check("wr1.rsp_resp",  32'(rsp_resp),  32'h0);
        check("wr1.rsp_rdata", rsp_rdata,      32'h0);
        tick();                                   // T3 edge: response consumed
        check_ctrl("wr1.t4", 0, 0, 0, 0, 0, 0, 1, S_IDLE);

        // ---- 2: read back 0x0010, accepted at T4
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010; cmd_prot = 3'b001;
        tick();
        cmd_valid = 1'b0;
        check_ctrl("rd1.req", 0, 0, 1, 0, 0, 0, 0, S_RD_REQ);
        check("rd1.araddr", 32'(araddr), 32'h0010);
        check("rd1.arprot", 32'(arprot), 32'h1);
        tick();
        check_ctrl("rd1.resp", 0, 0, 0, 0, 1, 0, 0, S_RD_RESP);
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = RESP_OKAY;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        check_ctrl("rd1.done", 0, 0, 0, 0, 0, 1, 0, S_DONE);
        check("rd1.rsp_rdata", rsp_rdata,      32'hDEADBEEF);
        check("rd1.rsp_write", 32'(rsp_write), 32'h0);
        check("rd1.rsp_resp",  32'(rsp_resp),  32'h0);
        tick();
        check_ctrl("rd1.idle", 0, 0, 0, 0, 0, 0, 1, S_IDLE);

        // ---- 3: AW completes 3 cycles before W; slave answers SLVERR
        awready = 1'b0; wready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0024;
        cmd_wdata = 32'h12345678; cmd_wstrb = 4'h3; cmd_prot = 3'b000;
        tick();
        cmd_valid = 1'b0;
        check_ctrl("wr2.a1", 1, 1, 0, 0, 0, 0, 0, S_WR_REQ);
        awready = 1'b1;
        tick();                                   // AW handshake only
        awready = 1'b0;
        check_ctrl("wr2.a2", 0, 1, 0, 0, 0, 0, 0, S_WR_REQ);
        check("wr2.a2.wdata", wdata,      32'h12345678);
        check("wr2.a2.wstrb", 32'(wstrb), 32'h3);
        tick();
        check_ctrl("wr2.a3", 0, 1, 0, 0, 0, 0, 0, S_WR_REQ);
        check("wr2.a3.wdata", wdata, 32'h12345678);
        tick();
        check_ctrl("wr2.a4", 0, 1, 0, 0, 0, 0, 0, S_WR_REQ);
        wready = 1'b1;
        tick();                                   // W handshake
        wready = 1'b0;
        check_ctrl("wr2.a5", 0, 0, 0, 1, 0, 0, 0, S_WR_RESP);
        bvalid = 1'b1; bresp = RESP_SLVERR;
        tick();
        bvalid = 1'b0; bresp = RESP_OKAY;
        check_ctrl("wr2.done", 0, 0, 0, 0, 0, 1, 0, S_DONE);
        check("wr2.rsp_resp",  32'(rsp_resp),  32'h2);
        check("wr2.rsp_write", 32'(rsp_write), 32'h1);
        tick();
        check_ctrl("wr2.idle", 0, 0, 0, 0, 0, 0, 1, S_IDLE);

        // ---- 4: read 0x0030, arready delayed 2 cycles, rvalid delayed 1, DECERR
        arready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0030; cmd_prot = 3'b100;
        tick();
        cmd_valid = 1'b0;
        check_ctrl("rd2.r1", 0, 0, 1, 0, 0, 0, 0, S_RD_REQ);
        tick();
        check_ctrl("rd2.r2", 0, 0, 1, 0, 0, 0, 0, S_RD_REQ);
        check("rd2.r2.araddr", 32'(araddr), 32'h0030);
        check("rd2.r2.arprot", 32'(arprot), 32'h4);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check_ctrl("rd2.r3", 0, 0, 0, 0, 1, 0, 0, S_RD_RESP);
        tick();                                   // rready waiting, no rvalid yet
        check_ctrl("rd2.r4", 0, 0, 0, 0, 1, 0, 0, S_RD_RESP);
        rvalid = 1'b1; rdata = 32'hAABBCCDD; rresp = RESP_DECERR;
        rsp_ready = 1'b0;
        tick();
        rvalid = 1'b0; rdata = 32'h0; rresp = RESP_OKAY;
        check_ctrl("rd2.done", 0, 0, 0, 0, 0, 1, 0, S_DONE);
        check("rd2.rsp_resp",  32'(rsp_resp), 32'h3);
        check("rd2.rsp_rdata", rsp_rdata,     32'hAABBCCDD);

        // ---- 5: response held 5 cycles with a write command waiting
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040;
        cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF; cmd_prot = 3'b000;
        awready = 1'b0; wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_ctrl("stall", 0, 0, 0, 0, 0, 1, 0, S_DONE);
            check("stall.rsp_rdata", rsp_rdata,     32'hAABBCCDD);
            check("stall.rsp_resp",  32'(rsp_resp), 32'h3);
        end
        rsp_ready = 1'b1;
        tick();                                   // response consumed
        check_ctrl("stall.idle", 0, 0, 0, 0, 0, 0, 1, S_IDLE);
        tick();                                   // pending write accepted now
        check_ctrl("rst2.wrreq", 1, 1, 0, 0, 0, 0, 0, S_WR_REQ);
        check("rst2.awaddr", 32'(awaddr), 32'h0040);

        // ---- 6: reset in WR_REQ, then a fresh read
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_ctrl("rst2.in", 0, 0, 0, 0, 0, 0, 0, S_IDLE);
        rst = 1'b0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        #1;
        check("rst2.cmd_ready", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0044; cmd_prot = 3'b000;
        tick();
        cmd_valid = 1'b0;
        check_ctrl("rd3.req", 0, 0, 1, 0, 0, 0, 0, S_RD_REQ);
        check("rd3.araddr", 32'(araddr), 32'h0044);
        tick();
        check_ctrl("rd3.resp", 0, 0, 0, 0, 1, 0, 0, S_RD_RESP);
        rvalid = 1'b1; rdata = 32'h0BADF00D; rresp = RESP_OKAY;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        check_ctrl("rd3.done", 0, 0, 0, 0, 0, 1, 0, S_DONE);
        check("rd3.rsp_rdata", rsp_rdata,      32'h0BADF00D);
        check("rd3.rsp_write", 32'(rsp_write), 32'h0);
        check("rd3.rsp_resp",  32'(rsp_resp),  32'h0);
        tick();
        check_ctrl("rd3.idle", 0, 0, 0, 0, 0, 0, 1, S_IDLE);

        // ---- report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
